rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Write-back controller for the 2-read/1-write register file. Arbitrates two
//  write-back sources (S0 = ALU, S1 = load unit) onto the single RF write port
//  via round-robin, with valid/ready handshakes. Keeps a per-register busy
//  scoreboard (set on issue, cleared on write-back) that decode uses for stalls.
// PARAMETERS
//  NREG  32  number of architectural registers; x0 is hardwired zero
//  AW     5  register address width, log2(NREG)
//  DW    32  data width
// PORTS
//  clk              in   1    clock, rising edge
//  rst_n            in   1    async reset, active low
//  i_rsv_en         in   1    issue: reserve destination register
//  i_rsv_addr       in   AW   register to mark busy
//  i_s0_valid       in   1    S0 write-back request
//  i_s0_addr        in   AW   S0 destination register
//  i_s0_data        in   DW   S0 write data
//  o_s0_ready       out  1    S0 request accepted this cycle
//  i_s1_valid/addr/data, o_s1_ready   same set of signals for S1
//  o_wr_en          out  1    RF write enable (registered)
//  o_wr_addr        out  AW   RF write address (registered)
//  o_wr_data        out  DW   RF write data (registered)
//  i_q_addr_1port   in   AW   hazard query, RF read port 1 address
//  i_q_addr_2port   in   AW   hazard query, RF read port 2 address
//  o_q_busy_1port   out  1    queried register has a pending write (comb.)
//  o_q_busy_2port   out  1    as above, port 2
//  o_fwd_vld_1port  out  1    forward hit, port 1 (bypass build only)
//  o_fwd_vld_2port  out  1    forward hit, port 2 (bypass build only)
//  o_fwd_data       out  DW   forwarded data = o_wr_data
//  o_busy_vec       out  NREG scoreboard contents; bit 0 is always 0
// BEHAVIOUR
//  - Reset (async): o_wr_en=0, o_wr_addr=0, o_wr_data=0, busy_vec=0,
//    rr_ptr=S0. Any request in flight is dropped; there is no internal buffer.
//  - Ready is combinational from valids and rr_ptr; the write port never stalls.
//    * Only one source valid: its ready = 1.
//    * Both valid: ready = 1 only for the source rr_ptr points to.
//    * At most one ready per cycle; a source is never ready if its valid = 0.
//  - Grant = valid & ready. On a grant, rr_ptr moves to the other source. With
//    no grant, rr_ptr holds. A source keeps valid/addr/data stable until ready.
//  - Latency 1: the grant on edge N sets o_wr_en/addr/data for cycle N+1; the
//    RF writes on edge N+1. A grant to x0 gives o_wr_en=0, but rr_ptr still moves.
//  - o_wr_en = 0 on any cycle with no grant on the previous edge.
//  - Scoreboard, evaluated per edge:
//    * i_rsv_en & addr!=0 sets busy[addr].
//    * o_wr_en clears busy[o_wr_addr], on the same edge the RF stores the data.
//    * Set and clear on the same register in one edge: set wins.
//    * Reserving a register that is already busy leaves it at 1 (no count).
//    * A write-back to a non-busy register still writes the RF; busy stays 0.
//  - o_q_busy_Xport = busy[i_q_addr_Xport]; x0 always 0.
// CONFIGURATION
//  Macro RF_WB_BYPASS_EN:
//  - Defined:
//    * o_fwd_vld_Xport = o_wr_en & (o_wr_addr == i_q_addr_Xport) & addr!=0.
//    * o_fwd_data = o_wr_data.
//    * o_q_busy_Xport is masked to 0 on a forward hit, so decode does not stall
//      in the write cycle.
//  - Undefined: o_fwd_vld_* = 0, o_fwd_data = 0; o_q_busy stays high through
//    the write cycle.
//  - Scoreboard timing is the same in both builds.
// TESTING
//  1 Reset: rst_n=0 mid-grant -> outputs 0 at once, busy_vec=0; after release
//    S0 and S1 both valid -> S0 wins first.
//  2 Solo: S1 valid addr=5 data=0xDEAD_BEEF -> o_s1_ready=1 same cycle; next
//    cycle o_wr_en=1, addr=5, data=0xDEADBEEF; RF r5 updated on that edge.
//  3 Contention: S0 and S1 held valid for 4 cycles -> grants S0,S1,S0,S1;
//    o_wr_en high for 4 consecutive cycles.
//  4 Scoreboard: reserve r7 -> busy[7]=1 and o_q_busy_1port(7)=1; S0 writes
//    r7 -> busy[7]=0 after the write edge. Reserve r7 on that same edge -> stays 1.
//  5 x0: reserve r0 plus S0 write r0 -> busy_vec[0]=0, o_wr_en=0, o_s0_ready=1.
//  6 Bypass (RF_WB_BYPASS_EN): r9 busy, o_wr_en to r9 with data=0x1234,
//    query port 2 = 9 -> o_fwd_vld_2port=1, o_fwd_data=0x1234,
//    o_q_busy_2port=0. Without the macro -> busy=1, fwd=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin between ALU (S0) and load unit (S1),
// one registered write port, per-register busy scoreboard. Optional bypass: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_rsv_en,
  input  logic [AW-1:0]   i_rsv_addr,
  input  logic            i_s0_valid,
  input  logic [AW-1:0]   i_s0_addr,
  input  logic [DW-1:0]   i_s0_data,
  output logic            o_s0_ready,
  input  logic            i_s1_valid,
  input  logic [AW-1:0]   i_s1_addr,
  input  logic [DW-1:0]   i_s1_data,
  output logic            o_s1_ready,
  output logic            o_wr_en,
  output logic [AW-1:0]   o_wr_addr,
  output logic [DW-1:0]   o_wr_data,
  input  logic [AW-1:0]   i_q_addr_1port,
  input  logic [AW-1:0]   i_q_addr_2port,
  output logic            o_q_busy_1port,
  output logic            o_q_busy_2port,
  output logic            o_fwd_vld_1port,
  output logic            o_fwd_vld_2port,
  output logic [DW-1:0]   o_fwd_data,
  output logic [NREG-1:0] o_busy_vec
);

  logic            rr_ptr;
  logic            grant_p0;
  logic [AW-1:0]   gnt_addr_p0;
  logic [DW-1:0]   gnt_data_p0;
  logic            wr_en_p1;
  logic [AW-1:0]   wr_addr_p1;
  logic [DW-1:0]   wr_data_p1;
  logic [NREG-1:0] busy_p1;
  logic [NREG-1:0] busy_nxt;
  logic            q_busy_1;
  logic            q_busy_2;

  // Stage p0: combinational arbitration; rr_ptr only matters when both sources request
  assign o_s0_ready  = i_s0_valid & (~i_s1_valid | ~rr_ptr);
  assign o_s1_ready  = i_s1_valid & (~i_s0_valid |  rr_ptr);
  assign grant_p0    = o_s0_ready | o_s1_ready;
  assign gnt_addr_p0 = o_s0_ready ? i_s0_addr : i_s1_addr;
  assign gnt_data_p0 = o_s0_ready ? i_s0_data : i_s1_data;

  always_comb begin
    busy_nxt = busy_p1;
    if (wr_en_p1)
      busy_nxt[wr_addr_p1] = 1'b0;
    if (i_rsv_en && (i_rsv_addr != '0))
      busy_nxt[i_rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Stage p1: registered write port and scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      busy_p1    <= '0;
    end else begin
      if (grant_p0) begin
        rr_ptr     <= o_s0_ready;
        wr_addr_p1 <= gnt_addr_p0;
        wr_data_p1 <= gnt_data_p0;
      end
      wr_en_p1 <= grant_p0 && (gnt_addr_p0 != '0);
      busy_p1  <= busy_nxt;
    end
  end

  assign o_wr_en    = wr_en_p1;
  assign o_wr_addr  = wr_addr_p1;
  assign o_wr_data  = wr_data_p1;
  assign o_busy_vec = busy_p1;
  assign q_busy_1   = busy_p1[i_q_addr_1port];
  assign q_busy_2   = busy_p1[i_q_addr_2port];

`ifdef RF_WB_BYPASS_EN
  // A hit means the value is on the write port now, so decode need not stall for it
  assign o_fwd_vld_1port = wr_en_p1 && (wr_addr_p1 == i_q_addr_1port) && (i_q_addr_1port != '0);
  assign o_fwd_vld_2port = wr_en_p1 && (wr_addr_p1 == i_q_addr_2port) && (i_q_addr_2port != '0);
  assign o_fwd_data      = wr_data_p1;
  assign o_q_busy_1port  = q_busy_1 & ~o_fwd_vld_1port;
  assign o_q_busy_2port  = q_busy_2 & ~o_fwd_vld_2port;
`else
  assign o_fwd_vld_1port = 1'b0;
  assign o_fwd_vld_2port = 1'b0;
  assign o_fwd_data      = '0;
  assign o_q_busy_1port  = q_busy_1;
  assign o_q_busy_2port  = q_busy_2;
`endif

endmodule
